approx_mul_engine: RTL and testbench

Streaming approximate multiplier engine with a built-in controller. It accepts unsigned operand pairs over a valid/ready handshake and normalises each operand by serial left-shift to find its leading one. It multiplies only the top K significant bits of each operand, then serially shifts the product back into place. It succeeds the RAM-bound fixed-width approximate datapath: operand width and kept-bit count are parameters, an exact mode is added, and I/O is stream-based so the block can sit between any producer and consumer in the CAD pipeline.

---
 rtl/approx_mul_engine.sv | 136 +++++++++++++
 tb/tb_approx_mul_engine.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_engine.sv
// Streaming approximate multiplier: normalises each operand, multiplies the top K
// bits, then shifts the product back into place. Exact mode bypasses truncation.
module approx_mul_engine #(
  parameter  int N  = 16,
  parameter  int K  = 8,
  localparam int SW = ($clog2(2*N-2*K+1) < 1) ? 1 : $clog2(2*N-2*K+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic            in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  out_result,
  output logic [SW-1:0]   out_shift,
  output logic            busy
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NORM   = 3'd1;
  localparam logic [2:0] S_MUL    = 3'd2;
  localparam logic [2:0] S_DENORM = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  logic [2:0]     state;
  logic           mode;
  logic [N-1:0]   work_a, work_b;
  logic [N-1:0]   orig_a, orig_b;
  logic [CW-1:0]  cnt_a, cnt_b;
  logic [2*N-1:0] prod;
  logic [SW-1:0]  shcnt;

  logic           done_a, done_b;
  logic [N-1:0]   t_a, t_b;
  logic [SW-1:0]  s_a, s_b, shift_sum;
  logic [2*N-1:0] product;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);

  // An operand is normalised once its MSB is set or it has shifted N-1 times (zero operand).
  assign done_a = work_a[N-1] || (cnt_a == CW'(N-1));
  assign done_b = work_b[N-1] || (cnt_b == CW'(N-1));

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    t_a = orig_a;
    t_b = orig_b;
    s_a = '0;
    s_b = '0;
    if (mode && (int'(cnt_a) <= N-K)) begin
      t_a = work_a >> (N-K);
      s_a = SW'(N - K - int'(cnt_a));
    end
    if (mode && (int'(cnt_b) <= N-K)) begin
      t_b = work_b >> (N-K);
      s_b = SW'(N - K - int'(cnt_b));
    end
    shift_sum = s_a + s_b;
    product   = {{N{1'b0}}, t_a} * {{N{1'b0}}, t_b};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mode       <= 1'b0;
      work_a     <= '0;
      work_b     <= '0;
      orig_a     <= '0;
      orig_b     <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      prod       <= '0;
      shcnt      <= '0;
      out_result <= '0;
      out_shift  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work_a <= in_a;
            work_b <= in_b;
            orig_a <= in_a;
            orig_b <= in_b;
            mode   <= in_mode;
            cnt_a  <= '0;
            cnt_b  <= '0;
            state  <= in_mode ? S_NORM : S_MUL;
          end
        end
        S_NORM: begin
          if (!done_a) begin
            work_a <= {work_a[N-2:0], 1'b0};
            cnt_a  <= cnt_a + 1'b1;
          end
          if (!done_b) begin
            work_b <= {work_b[N-2:0], 1'b0};
            cnt_b  <= cnt_b + 1'b1;
          end
          if (done_a && done_b) state <= S_MUL;
        end
        S_MUL: begin
          out_shift <= shift_sum;
          if (shift_sum == '0) begin
            out_result <= product;
            state      <= S_OUT;
          end else begin
            prod  <= product;
            shcnt <= shift_sum;
            state <= S_DENORM;
          end
        end
        S_DENORM: begin
          prod  <= {prod[2*N-2:0], 1'b0};
          shcnt <= shcnt - 1'b1;
          if (shcnt == SW'(1)) begin
            out_result <= {prod[2*N-2:0], 1'b0};
            state      <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mul_engine.sv
// Self-checking bench for approx_mul_engine: directed cases from the operating rules
// plus randomized operands scored against an arithmetic reference model.
module tb_approx_mul_engine;

  localparam int N  = 16;
  localparam int K  = 8;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a, in_b;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [2*N-1:0] out_result;
  logic [SW-1:0] out_shift;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  approx_mul_engine #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_shift(out_shift),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-operand normalisation and truncation, from the leading-one position.
  function automatic void trunc(input longint v, output longint t, output int s, output int c);
    int p = -1;
    for (int i = N-1; i >= 0; i--)
      if (p < 0 && ((v >> i) & 1) == 1) p = i;
    c = (p < 0) ? N-1 : N-1-p;
    if (c <= N-K) begin
      t = ((v << c) & ((64'd1 << N) - 1)) >> (N-K);
      s = N-K-c;
    end else begin
      t = v;
      s = 0;
    end
  endfunction

  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b, input logic mode,
                                output logic [2*N-1:0] res, output int sh, output int lat);
    longint ta, tb;
    int sa, sb, ca, cb;
    if (!mode) begin
      res = a * b;
      sh  = 0;
      lat = 2;
    end else begin
      trunc(longint'(a), ta, sa, ca);
      trunc(longint'(b), tb, sb, cb);
      res = (2*N)'((ta * tb) << (sa + sb));
      sh  = sa + sb;
      lat = ((ca > cb) ? ca : cb) + sh + 3;
    end
  endfunction

  // Called at a negedge with the engine idle. Latency counts edges from the accept edge (cycle 0).
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic mode,
                        input int hold, input logic [2*N-1:0] exp_res, input int exp_sh,
                        input int exp_lat);
    int j = 0;
    bit stable = 1'b1;
    check("in_ready_before_accept", in_ready, 1);
    in_a = a; in_b = b; in_mode = mode; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = N'($urandom); in_b = N'($urandom); in_mode = 1'($urandom);
    check("busy_after_accept", busy, 1);
    while (!out_valid && j < 200) begin
      @(posedge clk);
      @(negedge clk);
      j++;
    end
    check("timeout", (j >= 200), 0);
    check("latency", j + 1, exp_lat);
    check("result", out_result, exp_res);
    check("shift", out_shift, exp_sh);
    check("in_ready_in_out", in_ready, 0);
    if (mode) check("under_exact", (out_result <= a * b), 1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || out_result !== exp_res || out_shift !== SW'(exp_sh) || in_ready)
        stable = 1'b0;
    end
    if (hold > 0) check("backpressure_stable", stable, 1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_take", out_valid, 0);
    check("in_ready_after_take", in_ready, 1);
  endtask

  task automatic run_rand(input logic [N-1:0] a, input logic [N-1:0] b, input logic mode);
    logic [2*N-1:0] r;
    int s, l;
    model(a, b, mode, r, s, l);
    run_op(a, b, mode, int'($urandom_range(0, 2)), r, s, l);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_out_result"}, out_result, 0);
    check({tag, "_out_shift"}, out_shift, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Directed cases with hand-derived expectations.
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 32'hFE010000, 16, 19);
    run_op(16'h1234, 16'h0100, 1'b1, 0, 32'h00122000, 6, 16);
    run_op(16'h00FF, 16'h0003, 1'b1, 0, 32'h000002FD, 0, 17);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 32'hFFFE0001, 0, 2);
    run_op(16'h0000, 16'h0005, 1'b1, 0, 32'h00000000, 0, 18);
    run_op(16'h1234, 16'h0100, 1'b1, 10, 32'h00122000, 6, 16);

    // Reset during DENORM discards the operation.
    in_a = 16'hFFFF; in_b = 16'hFFFF; in_mode = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_denorm");
    run_op(16'h1234, 16'h0100, 1'b1, 0, 32'h00122000, 6, 16);

    // Reset while a result is pending in OUT.
    in_a = 16'h0003; in_b = 16'h0007; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pending_out_valid", out_valid, 1);
    out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    check_reset_state("rst_out");

    // Randomized operands with varied leading-one positions.
    for (int i = 0; i < 60; i++) begin
      logic [N-1:0] a, b;
      a = N'($urandom) >> $urandom_range(0, N);
      b = N'($urandom) >> $urandom_range(0, N);
      run_rand(a, b, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
